// File: rtl/sram_burst_ctrl.sv
// Splits one DATA_W-bit load/store into DATA_W/SRAM_DW beats on a narrow async SRAM,
// holding each beat for WAIT_CYC+1 cycles and stalling the pipeline via Ready.
module sram_burst_ctrl #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned SRAM_DW  = 16,
  parameter int unsigned ADDR_W   = 18,
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                MEM_W_EN,
  input  logic                MEM_R_EN,
  input  logic [31:0]         ALU_res,
  input  logic [DATA_W-1:0]   ST_Value,
  inout  wire  [SRAM_DW-1:0]  SRAM_data,
  output logic [DATA_W-1:0]   read_data,
  output logic                SRAM_WE_N,
  output logic                SRAM_OE_N,
  output logic [ADDR_W-1:0]   addr,
  output logic                Ready
);

  localparam int unsigned N  = DATA_W / SRAM_DW;
  localparam int unsigned BW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned WW = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(N - 1);
  localparam logic [WW-1:0] LAST_WAIT = WW'(WAIT_CYC);

  if (DATA_W % SRAM_DW != 0) begin : g_bad_width
    $error("sram_burst_ctrl: DATA_W must be an integer multiple of SRAM_DW");
  end

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_e;

  state_e              state_q;
  logic [BW-1:0]       beat_q;
  logic [WW-1:0]       wcnt_q;
  logic [DATA_W-1:0]   buf_q;
  logic [DATA_W-1:0]   rd_q;
  logic                we_n_q;
  logic                oe_n_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [SRAM_DW-1:0]  wdata_q;

  logic [BW-1:0]       next_beat_c;
  logic [ADDR_W-1:0]   next_addr_c;
  logic [SRAM_DW-1:0]  next_lane_c;
  logic [DATA_W-1:0]   rbuf_c;
  logic                beat_end_c;
  logic                last_beat_c;
  logic                unused_hi_c;

  // Address/lane of the beat about to start, and the read buffer with the live lane merged in
  always_comb begin
    beat_end_c  = (wcnt_q == LAST_WAIT);
    last_beat_c = (beat_q == LAST_BEAT);
    next_beat_c = (state_q == IDLE) ? '0 : beat_q + 1'b1;
    next_addr_c = ALU_res[ADDR_W-1:0] + ADDR_W'(next_beat_c);
    next_lane_c = '0;
    rbuf_c      = buf_q;
    for (int k = 0; k < int'(N); k++) begin
      if (next_beat_c == BW'(k)) next_lane_c = ST_Value[k*SRAM_DW +: SRAM_DW];
      if (beat_q == BW'(k))      rbuf_c[k*SRAM_DW +: SRAM_DW] = SRAM_data;
    end
  end

  assign unused_hi_c = ^(ALU_res >> ADDR_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      wcnt_q  <= '0;
      buf_q   <= '0;
      rd_q    <= '0;
      we_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          beat_q <= '0;
          wcnt_q <= '0;
          if (MEM_W_EN) begin
            state_q <= WRITE;
            we_n_q  <= 1'b0;
            addr_q  <= next_addr_c;
            wdata_q <= next_lane_c;
          end else if (MEM_R_EN) begin
            state_q <= READ;
            oe_n_q  <= 1'b0;
            addr_q  <= next_addr_c;
          end
        end
        WRITE, READ: begin
          if (state_q == READ && beat_end_c) buf_q <= rbuf_c;
          if (!beat_end_c) begin
            wcnt_q <= wcnt_q + 1'b1;
          end else begin
            wcnt_q <= '0;
            if (last_beat_c) begin
              state_q <= DONE;
              we_n_q  <= 1'b1;
              oe_n_q  <= 1'b1;
              addr_q  <= '0;
              if (state_q == READ) rd_q <= rbuf_c;
            end else begin
              beat_q  <= next_beat_c;
              addr_q  <= next_addr_c;
              wdata_q <= next_lane_c;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Ready is combinational in IDLE so a new request stalls the pipeline in its first cycle
  assign Ready     = (state_q == IDLE) ? ~(MEM_W_EN | MEM_R_EN) : (state_q == DONE);
  assign SRAM_data = we_n_q ? {SRAM_DW{1'bz}} : wdata_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign addr      = addr_q;
  assign read_data = rd_q;

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Scoreboard bench for sram_burst_ctrl: stimulus pushes expected bus beats and load
// results derived from a word-level memory model; a negedge monitor pops and compares.
module tb_sram_burst_ctrl;

  localparam int unsigned NB = 2;   // beats per 32-bit word
  localparam int unsigned WC = 1;   // extra wait cycles per beat

  logic        clk = 1'b0;
  logic        rst;
  logic        w_en, r_en;
  logic [31:0] alu, st;
  wire  [15:0] sram_data;
  logic [31:0] read_data;
  logic        we_n, oe_n, ready;
  logic [17:0] addr;

  logic        w64;
  logic [31:0] alu64;
  logic [63:0] st64;
  wire  [15:0] sd64;
  logic [63:0] rd64;
  logic        we64, oe64, rdy64;
  logic [17:0] a64;

  always #5 clk = ~clk;

  sram_burst_ctrl dut (
    .clk(clk), .rst(rst), .MEM_W_EN(w_en), .MEM_R_EN(r_en), .ALU_res(alu),
    .ST_Value(st), .SRAM_data(sram_data), .read_data(read_data),
    .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n), .addr(addr), .Ready(ready)
  );

  sram_burst_ctrl #(.DATA_W(64), .SRAM_DW(16), .ADDR_W(18), .WAIT_CYC(0)) dut64 (
    .clk(clk), .rst(rst), .MEM_W_EN(w64), .MEM_R_EN(1'b0), .ALU_res(alu64),
    .ST_Value(st64), .SRAM_data(sd64), .read_data(rd64),
    .SRAM_WE_N(we64), .SRAM_OE_N(oe64), .addr(a64), .Ready(rdy64)
  );

  // External SRAM model: unwritten locations return a fixed address-derived pattern
  function automatic logic [15:0] init_word(input logic [17:0] a);
    return a[15:0] ^ 16'hA5C3;
  endfunction

  logic [15:0] sram    [0:262143];
  bit          written [0:262143];
  logic [15:0] sram_rd;

  assign sram_rd   = written[addr] ? sram[addr] : init_word(addr);
  assign sram_data = oe_n ? 16'bz : sram_rd;

  always @(posedge clk) begin
    if (!we_n) begin
      sram[addr]    <= sram_data;
      written[addr] <= 1'b1;
    end
  end

  // Reference model state and scoreboard
  typedef struct {
    logic [17:0] a;
    logic        is_wr;
    logic [15:0] d;
  } beat_t;

  beat_t       exp_beats[$];
  logic [31:0] exp_rd[$];
  logic [15:0] ref_mem[int unsigned];
  logic [31:0] model_rd;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] ref_read(input logic [17:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
  endfunction

  beat_t mon_b;

  always @(negedge clk) begin
    if (!we_n || !oe_n) begin
      check("we_oe_exclusive", 64'(we_n | oe_n), 64'd1);
      if (exp_beats.size() == 0) begin
        check("unexpected_beat", 64'd1, 64'd0);
      end else begin
        mon_b = exp_beats.pop_front();
        check("beat_addr", 64'(addr), 64'(mon_b.a));
        check("beat_we_n", 64'(we_n), 64'(!mon_b.is_wr));
        check("beat_oe_n", 64'(oe_n), 64'(mon_b.is_wr));
        check("beat_data", 64'(sram_data), 64'(mon_b.d));
      end
    end
    if (ready && (w_en || r_en)) begin
      if (exp_rd.size() == 0) check("unexpected_done", 64'd1, 64'd0);
      else check("read_data_done", 64'(read_data), 64'(exp_rd.pop_front()));
    end
  end

  // Issue one access; reference expectations are computed per beat from the word rules
  task automatic access(input bit wr, input bit rd, input logic [17:0] a, input logic [31:0] v);
    int          lat;
    logic [31:0] word;
    logic [17:0] ak;
    logic [15:0] lane;
    word = '0;
    for (int k = 0; k < int'(NB); k++) begin
      ak = a + 18'(k);
      if (wr) begin
        lane = 16'(v >> (16 * k));
        ref_mem[int'(ak)] = lane;
      end else begin
        lane = ref_read(ak);
      end
      word = word | (32'(lane) << (16 * k));
      for (int c = 0; c <= int'(WC); c++) exp_beats.push_back('{ak, wr, lane});
    end
    if (!wr) model_rd = word;
    exp_rd.push_back(model_rd);
    w_en = wr;
    r_en = rd;
    alu  = {14'($urandom), a};
    st   = v;
    lat  = 0;
    @(negedge clk);
    while (!ready && lat < 50) begin
      lat++;
      @(negedge clk);
    end
    check("ready_latency", 64'(lat), 64'd5);
    @(posedge clk); #1;
    w_en = 1'b0;
    r_en = 1'b0;
  endtask

  task automatic idle_check(input string tag);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({tag, "_read_data"}, 64'(read_data), 64'(model_rd));
    check({tag, "_ready"}, 64'(ready), 64'd1);
    check({tag, "_we_n"}, 64'(we_n), 64'd1);
    check({tag, "_oe_n"}, 64'(oe_n), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int          lat, nb;
    logic [17:0] ra;
    int unsigned sel;
    logic [63:0] v64;

    rst = 1'b1; w_en = 1'b0; r_en = 1'b0; alu = '0; st = '0;
    w64 = 1'b0; alu64 = '0; st64 = '0; model_rd = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_we_n", 64'(we_n), 64'd1);
    check("reset_oe_n", 64'(oe_n), 64'd1);
    check("reset_addr", 64'(addr), 64'd0);
    check("reset_read_data", 64'(read_data), 64'd0);
    check("reset_ready", 64'(ready), 64'd1);
    @(posedge clk); #1;

    access(1'b1, 1'b0, 18'h00100, 32'hDEADBEEF);
    access(1'b0, 1'b1, 18'h00100, 32'h0);
    idle_check("load_hold");
    check("load_value", 64'(read_data), 64'h00000000DEADBEEF);

    access(1'b1, 1'b0, 18'h3FFFF, 32'h12345678);
    access(1'b0, 1'b1, 18'h3FFFF, 32'h0);
    check("wrap_load_value", 64'(model_rd), 64'h0000000012345678);

    access(1'b1, 1'b1, 18'h00200, 32'hCAFEF00D);
    idle_check("both_req");

    // Abort a load with reset during its third cycle
    ra = 18'h00100;
    exp_beats.push_back('{ra, 1'b0, ref_read(ra)});
    exp_beats.push_back('{ra, 1'b0, ref_read(ra)});
    r_en = 1'b1;
    alu  = 32'(ra);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    r_en = 1'b0;
    model_rd = '0;
    @(negedge clk);
    check("abort_we_n", 64'(we_n), 64'd1);
    check("abort_oe_n", 64'(oe_n), 64'd1);
    check("abort_read_data", 64'(read_data), 64'd0);
    check("abort_ready", 64'(ready), 64'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      ra  = 18'h3FFF0 + 18'($urandom_range(0, 31));
      if (sel < 4)      access(1'b1, 1'b0, ra, $urandom);
      else if (sel < 9) access(1'b0, 1'b1, ra, $urandom);
      else              access(1'b1, 1'b1, ra, $urandom);
    end
    idle_check("random_end");

    // 64-bit, zero-wait instance
    v64   = 64'h0011223344556677;
    w64   = 1'b1;
    alu64 = 32'h10;
    st64  = v64;
    lat   = 0;
    nb    = 0;
    @(negedge clk);
    while (!rdy64 && lat < 50) begin
      lat++;
      if (!we64) begin
        check("w64_addr", 64'(a64), 64'(18'h10 + 18'(nb)));
        check("w64_data", 64'(sd64), 64'(16'(v64 >> (16 * nb))));
        nb++;
      end
      @(negedge clk);
    end
    check("w64_ready_latency", 64'(lat), 64'd5);
    check("w64_beats", 64'(nb), 64'd4);
    @(posedge clk); #1;
    w64 = 1'b0;

    repeat (3) @(posedge clk);
    check("beats_drained", 64'(exp_beats.size()), 64'd0);
    check("loads_drained", 64'(exp_rd.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
